// File: rtl/vga_timing_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_delay_line_if
// Description : VGA timing bundle and mouse position, in and out of the
//               timing delay line. The master drives the live bundle and
//               receives the re-aligned one; the slave is the delay line.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_delay_line_if #(
    parameter int HCOUNT_W = 11,
    parameter int VCOUNT_W = 10,
    parameter int POS_W    = 12
);
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hblnk;
    logic                vblnk;
    logic                hsync;
    logic                vsync;
    logic [POS_W-1:0]    xpos_mouse_in;
    logic [POS_W-1:0]    ypos_mouse_in;

    logic [HCOUNT_W-1:0] hcount_out;
    logic [VCOUNT_W-1:0] vcount_out;
    logic                hblnk_out;
    logic                vblnk_out;
    logic                hsync_out;
    logic                vsync_out;
    logic [POS_W-1:0]    xpos_mouse_out;
    logic [POS_W-1:0]    ypos_mouse_out;
    logic                pipe_valid;
    logic                frame_start;

    modport master (
        output hcount, vcount, hblnk, vblnk, hsync, vsync,
               xpos_mouse_in, ypos_mouse_in,
        input  hcount_out, vcount_out, hblnk_out, vblnk_out, hsync_out,
               vsync_out, xpos_mouse_out, ypos_mouse_out, pipe_valid,
               frame_start
    );

    modport slave (
        input  hcount, vcount, hblnk, vblnk, hsync, vsync,
               xpos_mouse_in, ypos_mouse_in,
        output hcount_out, vcount_out, hblnk_out, vblnk_out, hsync_out,
               vsync_out, xpos_mouse_out, ypos_mouse_out, pipe_valid,
               frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_delay_line
// Description : DELAY-stage register pipeline for the VGA timing bundle and
//               mouse position, with optional once-per-frame mouse sampling,
//               a pipeline-filled flag and a frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_delay_line #(
    parameter int DELAY      = 2,
    parameter int HCOUNT_W   = 11,
    parameter int VCOUNT_W   = 10,
    parameter int POS_W      = 12,
    parameter int MOUSE_MODE = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    vga_timing_delay_line_if.slave bus
);

    if (DELAY < 1 || DELAY > 16) begin : g_delay_check
        $error("vga_timing_delay_line: DELAY must be in 1..16");
    end

    localparam int                  c_FILL_W   = $clog2(DELAY + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(DELAY);

    // Timing stages; index DELAY-1 is the output stage
    logic [HCOUNT_W-1:0] r_hcount [DELAY];
    logic [VCOUNT_W-1:0] r_vcount [DELAY];
    logic [2:0]          r_flags  [DELAY];  // {vsync, hsync, hblnk}
    logic [DELAY-1:0]    r_vblnk_pipe;

    // Mouse stages
    logic [POS_W-1:0]    r_xpos [DELAY];
    logic [POS_W-1:0]    r_ypos [DELAY];
    logic [POS_W-1:0]    w_xpos_d0;
    logic [POS_W-1:0]    w_ypos_d0;

    logic [c_FILL_W-1:0] r_fill_cnt;
    logic [c_FILL_W-1:0] w_fill_next;
    logic                r_pipe_valid;
    logic                r_frame_start;

    // vblnk chain: bit 0 is the live input, bit i+1 is stage i. Bit DELAY-1
    // is therefore what vblnk_out will hold after the next edge.
    logic [DELAY:0]      w_vblnk_chain;
    assign w_vblnk_chain = {r_vblnk_pipe, bus.vblnk};

    // Timing bundle shift register, cleared to zero on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_hcount[i] <= '0;
                r_vcount[i] <= '0;
                r_flags[i]  <= '0;
            end
            r_vblnk_pipe <= '0;
        end else begin
            r_hcount[0] <= bus.hcount;
            r_vcount[0] <= bus.vcount;
            r_flags[0]  <= {bus.vsync, bus.hsync, bus.hblnk};
            for (int i = 1; i < DELAY; i++) begin
                r_hcount[i] <= r_hcount[i-1];
                r_vcount[i] <= r_vcount[i-1];
                r_flags[i]  <= r_flags[i-1];
            end
            r_vblnk_pipe <= w_vblnk_chain[DELAY-1:0];
        end
    end

    if (MOUSE_MODE == 1) begin : g_mouse_frame
        logic             r_vblnk_prev;
        logic             w_vblnk_rise;
        logic [POS_W-1:0] r_xpos_latch;
        logic [POS_W-1:0] r_ypos_latch;

        assign w_vblnk_rise = bus.vblnk & ~r_vblnk_prev;
        // On the rise the fresh position bypasses the latch so that it
        // travels alongside the vblnk edge that triggered it.
        assign w_xpos_d0 = w_vblnk_rise ? bus.xpos_mouse_in : r_xpos_latch;
        assign w_ypos_d0 = w_vblnk_rise ? bus.ypos_mouse_in : r_ypos_latch;

        // Edge history and once-per-frame mouse latch
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vblnk_prev <= 1'b0;
                r_xpos_latch <= bus.xpos_mouse_in;
                r_ypos_latch <= bus.ypos_mouse_in;
            end else begin
                r_vblnk_prev <= bus.vblnk;
                if (w_vblnk_rise) begin
                    r_xpos_latch <= bus.xpos_mouse_in;
                    r_ypos_latch <= bus.ypos_mouse_in;
                end
            end
        end
    end else begin : g_mouse_live
        assign w_xpos_d0 = bus.xpos_mouse_in;
        assign w_ypos_d0 = bus.ypos_mouse_in;
    end

    // Mouse shift register; reset fills every stage with the live position
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_xpos[i] <= bus.xpos_mouse_in;
                r_ypos[i] <= bus.ypos_mouse_in;
            end
        end else begin
            r_xpos[0] <= w_xpos_d0;
            r_ypos[0] <= w_ypos_d0;
            for (int i = 1; i < DELAY; i++) begin
                r_xpos[i] <= r_xpos[i-1];
                r_ypos[i] <= r_ypos[i-1];
            end
        end
    end

    assign w_fill_next = (r_fill_cnt == c_FILL_MAX) ? r_fill_cnt
                                                    : r_fill_cnt + c_FILL_W'(1);

    // Fill tracking and frame-start pulse. frame_start is gated by the
    // current pipe_valid so the vblnk_out rise that coincides with the
    // end of fill (a reset artefact) never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt    <= '0;
            r_pipe_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_fill_cnt    <= w_fill_next;
            r_pipe_valid  <= (w_fill_next == c_FILL_MAX);
            r_frame_start <= w_vblnk_chain[DELAY-1] & ~w_vblnk_chain[DELAY]
                             & r_pipe_valid;
        end
    end

    assign bus.hcount_out     = r_hcount[DELAY-1];
    assign bus.vcount_out     = r_vcount[DELAY-1];
    assign bus.hblnk_out      = r_flags[DELAY-1][0];
    assign bus.hsync_out      = r_flags[DELAY-1][1];
    assign bus.vsync_out      = r_flags[DELAY-1][2];
    assign bus.vblnk_out      = w_vblnk_chain[DELAY];
    assign bus.xpos_mouse_out = r_xpos[DELAY-1];
    assign bus.ypos_mouse_out = r_ypos[DELAY-1];
    assign bus.pipe_valid     = r_pipe_valid;
    assign bus.frame_start    = r_frame_start;

endmodule
`default_nettype wire
